// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
// Optional fetch counter is enabled with the FETCH_CNT_EN macro.
package fetch_pkg;

    localparam int PC_W   = 7;
    localparam int INST_W = 8;
    localparam int CNT_W  = 16;

    localparam logic [INST_W-1:0] HALT_OPCODE = 8'hFF;
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// ROM and decode-side signals of the fetch unit; master = fetch unit, slave = ROM/decode/execute.
// fetch_cnt exists only when FETCH_CNT_EN is defined.
interface inst_fetch_if;
    import fetch_pkg::*;

    logic [PC_W-1:0]   rom_addr;
    logic [INST_W-1:0] rom_data;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic              branch_en;
    logic [PC_W-1:0]   branch_target;
    logic              halt;
`ifdef FETCH_CNT_EN
    logic [CNT_W-1:0]  fetch_cnt;

    modport master (
        output rom_addr, inst, inst_pc, inst_valid, halt, fetch_cnt,
        input  rom_data, inst_ready, branch_en, branch_target
    );
    modport slave (
        input  rom_addr, inst, inst_pc, inst_valid, halt, fetch_cnt,
        output rom_data, inst_ready, branch_en, branch_target
    );
`else
    modport master (
        output rom_addr, inst, inst_pc, inst_valid, halt,
        input  rom_data, inst_ready, branch_en, branch_target
    );
    modport slave (
        input  rom_addr, inst, inst_pc, inst_valid, halt,
        output rom_data, inst_ready, branch_en, branch_target
    );
`endif

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC, IDLE/FETCH/HALT control and the registered instruction to decode.
// Define FETCH_CNT_EN to add the saturating accepted-instruction counter (bus.fetch_cnt).
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    inst_fetch_if.master bus
);

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
    logic              valid_q, valid_d;
    logic              capture_ok;
    logic              accept;

    assign capture_ok = !valid_q || bus.inst_ready;
    assign accept     = valid_q && bus.inst_ready;

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;

        unique case (state_q)
            IDLE: begin
                if (accept) valid_d = 1'b0;
                if (start)  state_d = FETCH;
            end
            FETCH: begin
                // A redirect outranks both capture and halt detection.
                if (bus.branch_en) begin
                    pc_d    = bus.branch_target;
                    valid_d = 1'b0;
                end else if (capture_ok) begin
                    if (bus.rom_data == HALT_OPCODE) begin
                        valid_d = 1'b0;
                        state_d = HALT;
                    end else begin
                        inst_d    = bus.rom_data;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + PC_W'(1);
                    end
                end
            end
            HALT: begin
                if (bus.branch_en) begin
                    pc_d    = bus.branch_target;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (accept) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= START_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.rom_addr   = pc_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = valid_q;
    assign bus.halt       = (state_q == HALT);

`ifdef FETCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.fetch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: ROM model holds data=address for 0..9 and 8'hFF elsewhere;
// a second instance (START_PC=126, all-zero ROM) covers PC wrap and the optional counter.
module tb_inst_fetch;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic rst_n_w;
    logic start_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    inst_fetch_if bus ();
    inst_fetch_if wbus ();

    inst_fetch u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus)
    );

    inst_fetch #(.START_PC(7'd126)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n_w),
        .start (start_w),
        .bus   (wbus)
    );

    assign bus.rom_data  = (bus.rom_addr <= 7'd9) ? {1'b0, bus.rom_addr} : 8'hFF;
    assign wbus.rom_data = 8'h00;

    typedef struct {
        logic       start;
        logic       ready;
        logic       br;
        logic [6:0] tgt;
        logic       ev;
        logic       eh;
        logic [6:0] ea;
        logic [7:0] ei;
        logic [6:0] ep;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Packs {valid, halt, addr, inst, inst_pc}; inst/inst_pc only matter while valid.
    task automatic check_main(input string name, input logic ev, input logic eh,
                              input logic [6:0] ea, input logic [7:0] ei, input logic [6:0] ep);
        logic [31:0] act;
        logic [31:0] exp;
        act = {7'd0, bus.inst_valid, bus.halt, bus.rom_addr,
               (ev ? bus.inst : 8'd0), (ev ? bus.inst_pc : 7'd0)};
        exp = {7'd0, ev, eh, ea, (ev ? ei : 8'd0), (ev ? ep : 7'd0)};
        check(name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_main();
        rst_n = 1'b0;
        start = 1'b0;
        bus.inst_ready = 1'b1;
        bus.branch_en = 1'b0;
        bus.branch_target = '0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        rst_n_w = 1'b0;
        start_w = 1'b0;
        bus.inst_ready = 1'b1;
        bus.branch_en = 1'b0;
        bus.branch_target = '0;
        wbus.inst_ready = 1'b1;
        wbus.branch_en = 1'b0;
        wbus.branch_target = '0;

        // Straight-line fetch to HALT, restart from HALT, branch mid-stream, HALT again.
        vecs.push_back('{1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 8'd0, 7'd0});
        for (int i = 0; i < 10; i++)
            vecs.push_back('{1'b0, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 7'(i + 1), 8'(i), 7'(i)});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1, 7'd10, 8'd0, 7'd0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1, 7'd10, 8'd0, 7'd0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 7'd0, 1'b0, 1'b0, 7'd0, 8'd0, 7'd0});
        for (int i = 0; i < 3; i++)
            vecs.push_back('{1'b0, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 7'(i + 1), 8'(i), 7'(i)});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 7'd7, 1'b0, 1'b0, 7'd7, 8'd0, 7'd0});
        for (int i = 7; i < 10; i++)
            vecs.push_back('{1'b0, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 7'(i + 1), 8'(i), 7'(i)});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1, 7'd10, 8'd0, 7'd0});

        step();
        step();
        check("reset_outputs", {bus.inst_valid, bus.halt, bus.rom_addr, bus.inst, bus.inst_pc}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            start = vecs[i].start;
            bus.inst_ready = vecs[i].ready;
            bus.branch_en = vecs[i].br;
            bus.branch_target = vecs[i].tgt;
            step();
            check_main($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eh, vecs[i].ea, vecs[i].ei, vecs[i].ep);
        end
        start = 1'b0;
        bus.branch_en = 1'b0;

        // Back-pressure: hold 03 for three cycles, then drain a held 09 before halting.
        reset_main();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check_main("stall_pre", 1'b1, 1'b0, 7'd4, 8'h03, 7'd3);
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_main($sformatf("stall_hold%0d", i), 1'b1, 1'b0, 7'd4, 8'h03, 7'd3);
        end
        bus.inst_ready = 1'b1;
        step();
        check_main("stall_release", 1'b1, 1'b0, 7'd5, 8'h04, 7'd4);
        repeat (5) step();
        check_main("drain_pre", 1'b1, 1'b0, 7'd10, 8'h09, 7'd9);
        bus.inst_ready = 1'b0;
        step();
        check_main("drain_hold", 1'b1, 1'b0, 7'd10, 8'h09, 7'd9);
        bus.inst_ready = 1'b1;
        step();
        check_main("drain_halt", 1'b0, 1'b1, 7'd10, 8'h00, 7'd0);

        // Reset while an instruction is held; start and branch while idle.
        reset_main();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        check_main("mid_pre", 1'b1, 1'b0, 7'd6, 8'h05, 7'd5);
        rst_n = 1'b0;
        start = 1'b1;
        step();
        check_main("mid_reset", 1'b0, 1'b0, 7'd0, 8'h00, 7'd0);
        check("mid_reset_regs", {bus.inst, bus.inst_pc}, 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        bus.branch_en = 1'b1;
        bus.branch_target = 7'd5;
        step();
        check_main("idle_branch_ignored", 1'b0, 1'b0, 7'd0, 8'h00, 7'd0);
        bus.branch_en = 1'b0;
        start = 1'b1;
        step();
        check_main("start_latency1", 1'b0, 1'b0, 7'd0, 8'h00, 7'd0);
        start = 1'b0;
        step();
        check_main("start_latency2", 1'b1, 1'b0, 7'd1, 8'h00, 7'd0);

        // PC wrap on the second instance.
        step();
        check("wrap_reset_addr", {wbus.inst_valid, wbus.rom_addr}, {1'b0, 7'd126});
        rst_n_w = 1'b1;
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        check("wrap_start", {wbus.inst_valid, wbus.rom_addr}, {1'b0, 7'd126});
        for (int i = 0; i < 4; i++) begin
            logic [6:0] epc;
            epc = 7'(126 + i);
            step();
            check($sformatf("wrap_pc%0d", i), {wbus.inst_valid, wbus.inst_pc, wbus.rom_addr},
                  {1'b1, epc, epc + 7'd1});
        end
        step();
        check("wrap_next", {wbus.inst_valid, wbus.inst_pc}, {1'b1, 7'd2});
`ifdef FETCH_CNT_EN
        check("fetch_cnt", 32'(wbus.fetch_cnt), 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
